// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word-aligned request at a
// time to instruction memory and hands each fetched word (with its PC) to the
// decoder. Redirects from execute kill in-flight and held fetches.
module riscv_fetch_unit #(
    parameter int                     WORD_LENGTH = 32,
    parameter logic [WORD_LENGTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [WORD_LENGTH-1:0] imem_addr,
    input  logic                   imem_resp_valid,
    input  logic [WORD_LENGTH-1:0] imem_rdata,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [WORD_LENGTH-1:0] inst,
    output logic [WORD_LENGTH-1:0] inst_pc,
    input  logic                   redirect_valid,
    input  logic [WORD_LENGTH-1:0] redirect_pc,
    output logic                   misalign_o
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_VALID,
        S_DROP,
        S_HALT
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [WORD_LENGTH-1:0] pc;
    logic [WORD_LENGTH-1:0] pc_next;
    logic [WORD_LENGTH-1:0] inst_q;
    logic [WORD_LENGTH-1:0] inst_next;
    logic [WORD_LENGTH-1:0] inst_pc_q;
    logic [WORD_LENGTH-1:0] inst_pc_next;
    logic                   misalign_q;
    logic                   misalign_next;
    logic                   redirect_aligned;

    assign redirect_aligned = (redirect_pc[1:0] == 2'b00);

    // Outputs are forced low while reset is asserted so nothing leaks out of a stale state.
    assign imem_req_valid = ~rst & (state == S_REQ);
    assign imem_addr      = rst ? '0 : pc;
    assign inst_valid     = ~rst & (state == S_VALID);
    assign inst           = rst ? '0 : inst_q;
    assign inst_pc        = rst ? '0 : inst_pc_q;
    assign misalign_o     = ~rst & misalign_q;

    // Next-state logic: a redirect overrides every normal transition; HALT only leaves on reset.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        inst_next     = inst_q;
        inst_pc_next  = inst_pc_q;
        misalign_next = misalign_q;

        if (redirect_valid && (state != S_HALT)) begin
            if (!redirect_aligned) begin
                misalign_next = 1'b1;
                state_next    = S_HALT;
            end else begin
                pc_next = redirect_pc;
                case (state)
                    S_REQ:   state_next = imem_req_ready ? S_DROP : S_REQ;
                    S_WAIT:  state_next = imem_resp_valid ? S_REQ : S_DROP;
                    S_DROP:  state_next = S_DROP;
                    S_VALID: state_next = S_REQ;
                    default: state_next = state;
                endcase
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        inst_next    = imem_rdata;
                        inst_pc_next = pc;
                        state_next   = S_VALID;
                    end
                end
                S_VALID: begin
                    if (inst_ready) begin
                        pc_next    = pc + WORD_LENGTH'(4);
                        state_next = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_resp_valid) begin
                        state_next = S_REQ;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    // State register with synchronous reset back to RESET_PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            inst_q     <= '0;
            inst_pc_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            inst_q     <= inst_next;
            inst_pc_q  <= inst_pc_next;
            misalign_q <= misalign_next;
        end
    end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit: a small latency-programmable memory
// model answers requests, and each scenario checks hand-computed values.
module tb_riscv_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_o;

    // Second instance exercising a wrap-around reset PC, driven by hand.
    logic        rst2;
    logic        imem_req_valid2;
    logic        imem_req_ready2;
    logic [31:0] imem_addr2;
    logic        imem_resp_valid2;
    logic [31:0] imem_rdata2;
    logic        inst_valid2;
    logic        inst_ready2;
    logic [31:0] inst2;
    logic [31:0] inst_pc2;
    logic        redirect_valid2;
    logic [31:0] redirect_pc2;
    logic        misalign2;

    int passCount  = 0;
    int checkCount = 0;

    int          mem_lat    = 1;
    logic        mem_tagged = 1'b0;
    logic        hs_s       = 1'b0;
    logic        rst_s      = 1'b0;
    logic [31:0] hs_addr_s  = 32'h0;
    logic        pend       = 1'b0;
    int          pend_cnt   = 0;
    logic [31:0] pend_addr  = 32'h0;

    riscv_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_rdata      (imem_rdata),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .misalign_o      (misalign_o)
    );

    riscv_fetch_unit #(.WORD_LENGTH(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk             (clk),
        .rst             (rst2),
        .imem_req_valid  (imem_req_valid2),
        .imem_req_ready  (imem_req_ready2),
        .imem_addr       (imem_addr2),
        .imem_resp_valid (imem_resp_valid2),
        .imem_rdata      (imem_rdata2),
        .inst_valid      (inst_valid2),
        .inst_ready      (inst_ready2),
        .inst            (inst2),
        .inst_pc         (inst_pc2),
        .redirect_valid  (redirect_valid2),
        .redirect_pc     (redirect_pc2),
        .misalign_o      (misalign2)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return mem_tagged ? {addr[23:0], 8'h13} : 32'h0000_0013;
    endfunction

    // Sample the request handshake mid-cycle, where DUT outputs are settled.
    always @(negedge clk) begin
        hs_s      = imem_req_valid & imem_req_ready;
        hs_addr_s = imem_addr;
        rst_s     = rst;
    end

    // Memory model: a request accepted at edge t is answered for sampling at edge t+mem_lat.
    always @(posedge clk) begin
        #1;
        imem_resp_valid = 1'b0;
        if (rst_s) begin
            pend = 1'b0;
        end else if (hs_s) begin
            pend      = 1'b1;
            pend_cnt  = mem_lat - 1;
            pend_addr = hs_addr_s;
        end else if (pend && pend_cnt > 0) begin
            pend_cnt = pend_cnt - 1;
        end
        if (pend && pend_cnt == 0) begin
            imem_resp_valid = 1'b1;
            imem_rdata      = memWord(pend_addr);
            pend            = 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    task automatic applyStimulus(input logic req_rdy, input logic ir,
                                 input logic rv, input logic [31:0] rpc);
        imem_req_ready = req_rdy;
        inst_ready     = ir;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic advance(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One reset cycle with gated outputs checked; returns at the start of cycle 1.
    task automatic applyReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'h0);
        checkOutput("rst_inst_valid", 32'(inst_valid), 32'h0);
        checkOutput("rst_misalign", 32'(misalign_o), 32'h0);
        checkOutput("rst_addr", imem_addr, 32'h0);
        checkOutput("rst_inst", inst, 32'h0);
        checkOutput("rst_inst_pc", inst_pc, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        rst2 = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        imem_req_ready2  = 1'b1;
        imem_resp_valid2 = 1'b0;
        imem_rdata2      = 32'h0;
        inst_ready2      = 1'b1;
        redirect_valid2  = 1'b0;
        redirect_pc2     = 32'h0;

        $display("[TB] streaming fetch, 1-cycle memory");
        applyReset();
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checkOutput("t1_first_req", 32'(imem_req_valid), 32'h1);
                checkOutput("t1_first_addr", imem_addr, 32'h0);
            end
            checkOutput($sformatf("t1_valid_c%0d", c), 32'(inst_valid), 32'((c % 3) == 0));
            if ((c % 3) == 0) begin
                checkOutput($sformatf("t1_pc_c%0d", c), inst_pc, 32'((c / 3 - 1) * 4));
                checkOutput($sformatf("t1_inst_c%0d", c), inst, 32'h13);
            end
            advance(1);
        end

        $display("[TB] decoder backpressure");
        mem_tagged = 1'b1;
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        advance(3);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        advance(2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t2_hold_valid", 32'(inst_valid), 32'h1);
            checkOutput("t2_hold_pc", inst_pc, 32'h4);
            checkOutput("t2_hold_inst", inst, 32'h0000_0413);
            checkOutput("t2_no_req", 32'(imem_req_valid), 32'h0);
            advance(1);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("t2_release_valid", 32'(inst_valid), 32'h1);
        advance(1);
        @(negedge clk);
        checkOutput("t2_next_req", 32'(imem_req_valid), 32'h1);
        checkOutput("t2_next_addr", imem_addr, 32'h8);

        $display("[TB] redirect while waiting, 3-cycle memory");
        mem_lat = 3;
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("t3_req", 32'(imem_req_valid), 32'h1);
        advance(1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h100);
        @(negedge clk);
        checkOutput("t3_wait_no_req", 32'(imem_req_valid), 32'h0);
        advance(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("t3_drop_no_req", 32'(imem_req_valid), 32'h0);
        checkOutput("t3_drop_no_inst_c3", 32'(inst_valid), 32'h0);
        advance(1);
        @(negedge clk);
        checkOutput("t3_drop_no_inst_c4", 32'(inst_valid), 32'h0);
        advance(1);
        @(negedge clk);
        checkOutput("t3_stale_no_inst", 32'(inst_valid), 32'h0);
        checkOutput("t3_new_req", 32'(imem_req_valid), 32'h1);
        checkOutput("t3_new_addr", imem_addr, 32'h100);
        advance(1);
        for (int c = 6; c <= 8; c++) begin
            @(negedge clk);
            checkOutput($sformatf("t3_idle_c%0d", c), 32'(inst_valid), 32'h0);
            advance(1);
        end
        @(negedge clk);
        checkOutput("t3_valid", 32'(inst_valid), 32'h1);
        checkOutput("t3_pc", inst_pc, 32'h100);
        checkOutput("t3_inst", inst, 32'h0001_0013);

        $display("[TB] redirect coinciding with decoder handshake");
        mem_lat = 1;
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        advance(8);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
        @(negedge clk);
        checkOutput("t4_valid_at_8", 32'(inst_valid), 32'h1);
        checkOutput("t4_pc_8", inst_pc, 32'h8);
        advance(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("t4_no_repeat", 32'(inst_valid), 32'h0);
        checkOutput("t4_req", 32'(imem_req_valid), 32'h1);
        checkOutput("t4_addr", imem_addr, 32'h40);
        advance(2);
        @(negedge clk);
        checkOutput("t4_new_valid", 32'(inst_valid), 32'h1);
        checkOutput("t4_new_pc", inst_pc, 32'h40);

        $display("[TB] misaligned redirect");
        advance(1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h102);
        @(negedge clk);
        checkOutput("t5_pre_addr", imem_addr, 32'h44);
        checkOutput("t5_pre_misalign", 32'(misalign_o), 32'h0);
        advance(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t5_misalign", 32'(misalign_o), 32'h1);
            checkOutput("t5_no_req", 32'(imem_req_valid), 32'h0);
            checkOutput("t5_no_inst", 32'(inst_valid), 32'h0);
            checkOutput("t5_pc_kept", imem_addr, 32'h44);
            advance(1);
        end
        applyReset();
        @(negedge clk);
        checkOutput("t5_after_rst_misalign", 32'(misalign_o), 32'h0);
        checkOutput("t5_after_rst_req", 32'(imem_req_valid), 32'h1);
        checkOutput("t5_after_rst_addr", imem_addr, 32'h0);

        $display("[TB] reset PC at top of address space");
        advance(1);
        rst2 = 1'b0;
        @(negedge clk);
        checkOutput("t6_req", 32'(imem_req_valid2), 32'h1);
        checkOutput("t6_addr", imem_addr2, 32'hFFFF_FFFC);
        advance(1);
        imem_resp_valid2 = 1'b1;
        imem_rdata2      = 32'h0000_0013;
        @(negedge clk);
        checkOutput("t6_wait_no_req", 32'(imem_req_valid2), 32'h0);
        advance(1);
        imem_resp_valid2 = 1'b0;
        @(negedge clk);
        checkOutput("t6_valid", 32'(inst_valid2), 32'h1);
        checkOutput("t6_pc", inst_pc2, 32'hFFFF_FFFC);
        checkOutput("t6_inst", inst2, 32'h0000_0013);
        advance(1);
        @(negedge clk);
        checkOutput("t6_wrap_req", 32'(imem_req_valid2), 32'h1);
        checkOutput("t6_wrap_addr", imem_addr2, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
